sound_multi: RTL and testbench
==============================

// Module: sound_multi
// PURPOSE
//  Parametrised successor to the single-tone sound block: NUM_CHANNELS square-wave tone generators,
//  each with its own half-period and optional auto-stop duration. Channels are mixed onto the single
//  buzzer pin. Sits beside the CPU at top level and is programmed through a channel-addressed latch port.
// PARAMETERS
//  NUM_CHANNELS  4      number of tone channels (>=1)
//  CNT_WIDTH     26     half-period counter width (covers <1 Hz at 50 MHz)
//  DUR_WIDTH     16     duration counter width, in duration ticks
//  TICK_DIV      50000  clk cycles per duration tick (1 ms at 50 MHz), >=2
//  MIX_MODE      0      0 = logical OR of channel phases; 1 = first-order sigma-delta of phase sum
// PORTS
//  clk             in   1                  system clock (50 MHz)
//  n_rst_async     in   1                  asynchronous active-low reset
//  ch_sel          in   CH_W=max(1,$clog2(NUM_CHANNELS))  channel addressed by latch
//  max_count       in   CNT_WIDTH          half-period in clk cycles; 0 = silence/stop
//  duration        in   DUR_WIDTH          note length in ticks; 0 = play until re-latched
//  latch           in   1                  1-cycle strobe: load max_count/duration into ch_sel
//  channel_active  out  NUM_CHANNELS       bit i = channel i currently sounding
//  buzzer          out  1                  mixed 1-bit audio output, registered
// BEHAVIOUR
//  - Reset (n_rst_async low, any time incl. mid-note): all state cleared; buzzer=0, channel_active=0,
//    prescaler=0, sigma-delta accumulator=0. Per-channel period, count, phase and remaining are all 0.
//  - Latch at edge k, ch_sel<NUM_CHANNELS: period<=max_count, count<=0, phase<=0, remaining<=duration,
//    active<=(max_count!=0). ch_sel>=NUM_CHANNELS: latch ignored. Re-latch of a playing channel restarts it.
//  - Tone: while active, count increments each edge; when count==period-1 the channel sets count<=0
//    and toggles phase. The phase therefore toggles at edges k+P, k+2P, ..., where P = max_count,
//    giving f = f_clk/(2P). P=1 toggles every cycle.
//  - Inactive channel: phase forced 0, count held 0.
//  - Prescaler: free-running 0..TICK_DIV-1; tick=1 for the one cycle it wraps; not reset by latch.
//  - Duration: on tick, an active channel with remaining!=0 decrements remaining. When remaining==1
//    on a tick, the channel sets active<=0 and phase<=0 on the same edge. remaining==0 never expires.
//    A note latched with duration=D therefore ends on the D-th tick after the latch.
//  - Same-cycle latch and tick on the same channel: the latch wins and the tick is not applied.
//  - channel_active is a direct view of the per-channel active flags (0 cycles after the flag edge).
//  - MIX_MODE 0: buzzer<=|phase[]; output is 1 edge after the phase change.
//  - MIX_MODE 1: s=popcount(phase[]), width SW=$clog2(NUM_CHANNELS+1); a=acc+s (SW+1 bits);
//    if a>=NUM_CHANNELS then buzzer<=1 and acc<=a-NUM_CHANNELS, else buzzer<=0 and acc<=a.
//    acc stays in [0,NUM_CHANNELS). Long-run buzzer density = s/NUM_CHANNELS. Latency is 1 edge.
//  - All arithmetic is unsigned; no counter saturates other than as stated above.
// STRUCTURE
//  - Shared package: mix-mode enum {MIX_OR, MIX_SIGMA_DELTA}; SND_DEFAULT_TICK_DIV constant.
//  - Sub-module sound_channel (period/count/phase/remaining/active). It is instantiated NUM_CHANNELS
//    times in a generate loop; each instance takes load, tick, max_count and duration, and produces
//    phase and active.
//  - Top level holds the prescaler, ch_sel decode and mixer.
// TESTING
//  1. Assert n_rst_async low mid-note -> buzzer=0 and channel_active=0 immediately; no activity after release.
//  2. N=4, MIX 0: latch ch0 P=3 D=0 at edge k -> buzzer rises at k+4, falls at k+7, and so on;
//     channel_active=4'b0001 indefinitely.
//  3. TICK_DIV=10: latch ch1 P=2 D=2 -> channel_active[1] clears on the 2nd tick after the latch,
//     after which buzzer stays 0.
//  4. Playing ch2, latch ch2 with P=0 -> channel_active[2]=0 the next cycle and buzzer 0 one edge later.
//  5. MIX 1, N=4: ch0 and ch1 both P=1000 latched together -> during their high half, exactly 50
//     of any 100 consecutive buzzer cycles are 1 (±1).
//  6. N=3: latch with ch_sel=3 -> no state change. Latch ch0 on its expiring tick cycle -> ch0 restarts
//     and stays active.

Source files
------------

// File: rtl/sound_multi_pkg.sv
// Shared definitions for the multi-channel tone generator: mixer modes,
// default tick divider and the channel-select width helper.
package sound_multi_pkg;

    typedef enum logic {
        MIX_OR          = 1'b0,
        MIX_SIGMA_DELTA = 1'b1
    } mix_mode_e;

    localparam int SND_DEFAULT_TICK_DIV = 50000;

    function automatic int sel_width(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

endpackage

// File: rtl/sound_multi_if.sv
// Channel-addressed programming port of sound_multi: the CPU side drives a
// channel number, half-period and duration, then strobes latch for one cycle.
interface sound_multi_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 26,
    parameter int DUR_WIDTH    = 16
);
    localparam int CH_W = sound_multi_pkg::sel_width(NUM_CHANNELS);

    logic [CH_W-1:0]      ch_sel;
    logic [CNT_WIDTH-1:0] max_count;
    logic [DUR_WIDTH-1:0] duration;
    logic                 latch;

    modport master (output ch_sel, output max_count, output duration, output latch);
    modport slave  (input  ch_sel, input  max_count, input  duration, input  latch);

endinterface

// File: rtl/sound_multi_channel.sv
// One square-wave tone channel: half-period counter, phase flip-flop and an
// optional tick-based duration that silences the channel when it runs out.
module sound_channel #(
    parameter int CNT_WIDTH = 26,
    parameter int DUR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_rst_async,
    input  logic                 load,
    input  logic                 tick,
    input  logic [CNT_WIDTH-1:0] max_count,
    input  logic [DUR_WIDTH-1:0] duration,
    output logic                 phase,
    output logic                 active
);

    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] count;
    logic [DUR_WIDTH-1:0] remaining;

    // A load always wins over a same-cycle tick; remaining==0 means the note never expires.
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            period    <= '0;
            count     <= '0;
            phase     <= 1'b0;
            remaining <= '0;
            active    <= 1'b0;
        end else if (load) begin
            period    <= max_count;
            count     <= '0;
            phase     <= 1'b0;
            remaining <= duration;
            active    <= (max_count != '0);
        end else if (active) begin
            if (tick && remaining == DUR_WIDTH'(1)) begin
                active    <= 1'b0;
                phase     <= 1'b0;
                count     <= '0;
                remaining <= '0;
            end else begin
                if (tick && remaining != '0) begin
                    remaining <= remaining - DUR_WIDTH'(1);
                end
                if (count == period - CNT_WIDTH'(1)) begin
                    count <= '0;
                    phase <= ~phase;
                end else begin
                    count <= count + CNT_WIDTH'(1);
                end
            end
        end else begin
            phase <= 1'b0;
            count <= '0;
        end
    end

endmodule

// File: rtl/sound_multi.sv
// Multi-channel buzzer driver: shared duration prescaler, channel-select decode,
// NUM_CHANNELS tone channels and a registered OR or sigma-delta mixer.
module sound_multi
    import sound_multi_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 26,
    parameter int DUR_WIDTH    = 16,
    parameter int TICK_DIV     = SND_DEFAULT_TICK_DIV,
    parameter int MIX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    n_rst_async,
    sound_multi_if.slave            bus,
    output logic [NUM_CHANNELS-1:0] channel_active,
    output logic                    buzzer
);

    localparam int CH_W = sel_width(NUM_CHANNELS);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int SW   = $clog2(NUM_CHANNELS + 1);

    logic [PW-1:0]           prescaler;
    logic                    tick;
    logic [NUM_CHANNELS-1:0] load;
    logic [NUM_CHANNELS-1:0] phase;
    logic [NUM_CHANNELS-1:0] active;

    assign tick = (prescaler == PW'(TICK_DIV - 1));

    // Free-running duration prescaler; programming the channels never disturbs it.
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        assign load[i] = bus.latch && (bus.ch_sel == CH_W'(i));

        sound_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .DUR_WIDTH (DUR_WIDTH)
        ) u_channel (
            .clk         (clk),
            .n_rst_async (n_rst_async),
            .load        (load[i]),
            .tick        (tick),
            .max_count   (bus.max_count),
            .duration    (bus.duration),
            .phase       (phase[i]),
            .active      (active[i])
        );
    end

    assign channel_active = active;

    if (MIX_MODE == int'(MIX_SIGMA_DELTA)) begin : g_mix_sd
        localparam logic [SW:0] CH_COUNT = (SW + 1)'(NUM_CHANNELS);

        logic [SW-1:0] acc;
        logic [SW-1:0] phase_sum;
        logic [SW:0]   acc_next;

        always_comb begin
            phase_sum = '0;
            for (int j = 0; j < NUM_CHANNELS; j++) begin
                phase_sum = phase_sum + SW'(phase[j]);
            end
            acc_next = {1'b0, acc} + {1'b0, phase_sum};
        end

        // Accumulator stays below NUM_CHANNELS, so buzzer density tracks phase_sum/NUM_CHANNELS.
        always_ff @(posedge clk or negedge n_rst_async) begin
            if (!n_rst_async) begin
                acc    <= '0;
                buzzer <= 1'b0;
            end else if (acc_next >= CH_COUNT) begin
                acc    <= SW'(acc_next - CH_COUNT);
                buzzer <= 1'b1;
            end else begin
                acc    <= SW'(acc_next);
                buzzer <= 1'b0;
            end
        end
    end else begin : g_mix_or
        always_ff @(posedge clk or negedge n_rst_async) begin
            if (!n_rst_async) begin
                buzzer <= 1'b0;
            end else begin
                buzzer <= |phase;
            end
        end
    end

endmodule

// File: tb/tb_sound_multi.sv
// Self-checking bench for sound_multi: three instances (4-channel OR mixer,
// 4-channel sigma-delta mixer, 3-channel OR mixer) against a note-timeline model.
module tb_sound_multi;

    localparam int TD = 10;
    localparam int CW = 26;
    localparam int DW = 16;

    typedef struct {
        int ch;
        int k;
        int p;
        int d;
    } note_t;

    logic       clk;
    logic       n_rst;
    logic [3:0] act_a;
    logic       buz_a;
    logic [3:0] act_s;
    logic       buz_s;
    logic [2:0] act_t;
    logic       buz_t;

    int    edge_cnt;
    int    n_checks;
    int    n_fail;
    int    last_k;
    note_t notes[$];

    sound_multi_if #(.NUM_CHANNELS(4)) bus_a ();
    sound_multi_if #(.NUM_CHANNELS(4)) bus_s ();
    sound_multi_if #(.NUM_CHANNELS(3)) bus_t ();

    sound_multi #(.NUM_CHANNELS(4), .TICK_DIV(TD), .MIX_MODE(0)) dut_a (
        .clk(clk), .n_rst_async(n_rst), .bus(bus_a), .channel_active(act_a), .buzzer(buz_a));

    sound_multi #(.NUM_CHANNELS(4), .TICK_DIV(TD), .MIX_MODE(1)) dut_s (
        .clk(clk), .n_rst_async(n_rst), .bus(bus_s), .channel_active(act_s), .buzzer(buz_s));

    sound_multi #(.NUM_CHANNELS(3), .TICK_DIV(TD), .MIX_MODE(0)) dut_t (
        .clk(clk), .n_rst_async(n_rst), .bus(bus_t), .channel_active(act_t), .buzzer(buz_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: a note latched at edge k plays until the d-th prescaler tick after k.
    function automatic int find_note(input int ch, input int n);
        for (int i = notes.size() - 1; i >= 0; i--) begin
            if (notes[i].ch == ch && notes[i].k <= n) return i;
        end
        return -1;
    endfunction

    function automatic bit m_active(input int ch, input int n);
        int idx;
        int first_tick;
        idx = find_note(ch, n);
        if (idx < 0) return 1'b0;
        if (notes[idx].p == 0) return 1'b0;
        if (notes[idx].d == 0) return 1'b1;
        first_tick = (notes[idx].k / TD + 1) * TD;
        return n < first_tick + (notes[idx].d - 1) * TD;
    endfunction

    function automatic bit m_phase(input int ch, input int n);
        int idx;
        if (!m_active(ch, n)) return 1'b0;
        idx = find_note(ch, n);
        return ((n - notes[idx].k) / notes[idx].p) % 2 != 0;
    endfunction

    function automatic logic [3:0] m_active_vec(input int n);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = m_active(c, n);
        return v;
    endfunction

    function automatic logic m_buzzer(input int n);
        logic b;
        b = 1'b0;
        if (n < 1) return 1'b0;
        for (int c = 0; c < 4; c++) b = b | m_phase(c, n - 1);
        return b;
    endfunction

    task automatic latch_a(input int ch, input int p, input int d);
        note_t nt;
        bus_a.ch_sel    = 2'(ch);
        bus_a.max_count = CW'(p);
        bus_a.duration  = DW'(d);
        bus_a.latch     = 1'b1;
        last_k = edge_cnt + 1;
        nt.ch = ch; nt.k = last_k; nt.p = p; nt.d = d;
        notes.push_back(nt);
        @(negedge clk);
        bus_a.latch = 1'b0;
    endtask

    task automatic latch_t(input int ch, input int p, input int d);
        bus_t.ch_sel    = 2'(ch);
        bus_t.max_count = CW'(p);
        bus_t.duration  = DW'(d);
        bus_t.latch     = 1'b1;
        last_k = edge_cnt + 1;
        @(negedge clk);
        bus_t.latch = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        n_checks++;
        if (act_a !== 4'b0 || buz_a !== 1'b0 || act_s !== 4'b0 || buz_s !== 1'b0 ||
            act_t !== 3'b0 || buz_t !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: act_a=%b buz_a=%b act_s=%b buz_s=%b act_t=%b buz_t=%b required all 0",
                     act_a, buz_a, act_s, buz_s, act_t, buz_t);
        end
        latch_a(0, 3, 0);
        repeat (10) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if (act_a !== 4'b0 || buz_a !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_note: act=%b buz=%b required 0000/0", act_a, buz_a);
        end
        @(negedge clk);
        notes.delete();
        n_rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            n_checks++;
            if (act_a !== 4'b0 || buz_a !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL after_reset_idle edge %0d: act=%b buz=%b required 0000/0", edge_cnt, act_a, buz_a);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tone();
        int dk;
        logic want;
        latch_a(0, 3, 0);
        for (int c = 0; c < 30; c++) begin
            dk = edge_cnt - last_k;
            n_checks++;
            if (act_a !== 4'b0001 || buz_a !== m_buzzer(edge_cnt)) begin
                n_fail++;
                $display("[TB] FAIL tone_p3 edge k+%0d: act=%b buz=%b required 0001/%b",
                         dk, act_a, buz_a, m_buzzer(edge_cnt));
            end
            if (dk == 3 || dk == 4 || dk == 7 || dk == 10) begin
                want = (dk == 4 || dk == 10);
                n_checks++;
                if (buz_a !== want) begin
                    n_fail++;
                    $display("[TB] FAIL tone_edges k+%0d: buz=%b required %b", dk, buz_a, want);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_duration();
        int t_end;
        latch_a(0, 0, 0);
        latch_a(1, 2, 2);
        t_end = (last_k / TD + 2) * TD;
        for (int c = 0; c < 45; c++) begin
            n_checks++;
            if (act_a !== m_active_vec(edge_cnt) || buz_a !== m_buzzer(edge_cnt)) begin
                n_fail++;
                $display("[TB] FAIL duration edge %0d: act=%b buz=%b required %b/%b",
                         edge_cnt, act_a, buz_a, m_active_vec(edge_cnt), m_buzzer(edge_cnt));
            end
            if (edge_cnt == t_end - 1 || edge_cnt == t_end + 2) begin
                n_checks++;
                if (act_a[1] !== (edge_cnt < t_end)) begin
                    n_fail++;
                    $display("[TB] FAIL duration_expiry edge %0d: act1=%b required %b",
                             edge_cnt, act_a[1], edge_cnt < t_end);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stop();
        latch_a(2, 5, 0);
        repeat (17) @(negedge clk);
        latch_a(2, 0, 0);
        n_checks++;
        if (act_a[2] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stop_active: act2=%b required 0", act_a[2]);
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (act_a !== m_active_vec(edge_cnt) || buz_a !== m_buzzer(edge_cnt)) begin
                n_fail++;
                $display("[TB] FAIL stop edge %0d: act=%b buz=%b required %b/%b",
                         edge_cnt, act_a, buz_a, m_active_vec(edge_cnt), m_buzzer(edge_cnt));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 12; r++) begin
            latch_a($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                latch_a($urandom_range(0, 3), $urandom_range(1, 5), $urandom_range(0, 2));
            end
            len = $urandom_range(3, 40);
            for (int c = 0; c < len; c++) begin
                n_checks++;
                if (act_a !== m_active_vec(edge_cnt) || buz_a !== m_buzzer(edge_cnt)) begin
                    n_fail++;
                    $display("[TB] FAIL random edge %0d: act=%b buz=%b required %b/%b",
                             edge_cnt, act_a, buz_a, m_active_vec(edge_cnt), m_buzzer(edge_cnt));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_sigma_delta();
        int k;
        int ones;
        bus_s.ch_sel = 2'd0; bus_s.max_count = CW'(1000); bus_s.duration = '0; bus_s.latch = 1'b1;
        k = edge_cnt + 1;
        @(negedge clk);
        bus_s.ch_sel = 2'd1;
        @(negedge clk);
        bus_s.latch = 1'b0;
        while (edge_cnt < k + 500) @(negedge clk);
        ones = 0;
        for (int c = 0; c < 100; c++) begin
            ones += int'(buz_s);
            @(negedge clk);
        end
        n_checks++;
        if (ones != 0 || act_s !== 4'b0011) begin
            n_fail++;
            $display("[TB] FAIL sd_low_half: ones=%0d act=%b required 0/0011", ones, act_s);
        end
        while (edge_cnt < k + 1100) @(negedge clk);
        ones = 0;
        for (int c = 0; c < 100; c++) begin
            ones += int'(buz_s);
            @(negedge clk);
        end
        n_checks++;
        if (ones < 49 || ones > 51) begin
            n_fail++;
            $display("[TB] FAIL sd_density: ones=%0d in 100 required 50+-1", ones);
        end
    endtask

    task automatic test_three_channels();
        int t1;
        logic want;
        latch_t(3, 4, 0);
        for (int c = 0; c < 20; c++) begin
            n_checks++;
            if (act_t !== 3'b000 || buz_t !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL ignored_sel edge %0d: act=%b buz=%b required 000/0", edge_cnt, act_t, buz_t);
            end
            @(negedge clk);
        end
        latch_t(0, 2, 1);
        t1 = (last_k / TD + 1) * TD;
        while (edge_cnt < t1 - 1) @(negedge clk);
        n_checks++;
        if (act_t !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL pre_expiry: act=%b required 001", act_t);
        end
        latch_t(0, 2, 0);
        for (int c = 0; c < 30; c++) begin
            want = (edge_cnt > t1) ? (((edge_cnt - 1 - t1) / 2) % 2 != 0) : buz_t;
            n_checks++;
            if (act_t !== 3'b001 || buz_t !== want) begin
                n_fail++;
                $display("[TB] FAIL relatch_on_tick edge t1+%0d: act=%b buz=%b required 001/%b",
                         edge_cnt - t1, act_t, buz_t, want);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        bus_a.ch_sel = '0; bus_a.max_count = '0; bus_a.duration = '0; bus_a.latch = 1'b0;
        bus_s.ch_sel = '0; bus_s.max_count = '0; bus_s.duration = '0; bus_s.latch = 1'b0;
        bus_t.ch_sel = '0; bus_t.max_count = '0; bus_t.duration = '0; bus_t.latch = 1'b0;
        @(negedge clk);
        test_reset();
        test_tone();
        test_duration();
        test_stop();
        test_random();
        test_sigma_delta();
        test_three_channels();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
